nand_cmd_sequencer: RTL and testbench

//  Sequences ONFI SDR (asynchronous) bus cycles for the nand_controller pin interface.
//  Per accepted request it issues:
//   - a command latch;
//   - 0-5 address latches;
//   - an optional second command latch;
//   - an optional ready/busy (R/B#) wait with timeout;
//   - 0-255 data-out read cycles.
//  It sits between the controller's operation layer (READ STATUS, READ ID, PAGE READ,

---
 rtl/nand_cmd_sequencer.sv | 174 +++++++++++++++++
 tb/tb_nand_cmd_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nand_cmd_sequencer.sv
// ONFI SDR bus-cycle sequencer: command/address latches, optional R/B# wait and
// data-out read cycles for one request at a time, with all pin timing in clk cycles.
module nand_cmd_sequencer #(
  parameter int T_WP  = 2,
  parameter int T_WH  = 2,
  parameter int T_RP  = 2,
  parameter int T_REH = 2,
  parameter int T_WB  = 4,
  parameter int TO_W  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd1,
  input  logic        req_has_cmd2,
  input  logic [7:0]  req_cmd2,
  input  logic [39:0] req_addr,
  input  logic [2:0]  req_naddr,
  input  logic        req_wait_rb,
  input  logic [7:0]  req_nread,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        timeout,
  output logic        ce_n,
  output logic        cle,
  output logic        ale,
  output logic        we_n,
  output logic        re_n,
  output logic [7:0]  io_out,
  output logic        io_oe,
  input  logic [7:0]  io_in,
  input  logic        rb_n
);

  typedef enum logic [2:0] {IDLE, CMD1, ADDR, CMD2, WB, WAIT_RB, READ, DONE} state_t;

  localparam logic [15:0] LAT_LAST = 16'(T_WP + T_WH - 1);
  localparam logic [15:0] WP_N     = 16'(T_WP);
  localparam logic [15:0] RD_LAST  = 16'(T_RP + T_REH - 1);
  localparam logic [15:0] RP_N     = 16'(T_RP);
  localparam logic [15:0] RP_LAST  = 16'(T_RP - 1);
  localparam logic [15:0] WB_LAST  = 16'(T_WB - 1);
  // 2**TO_W-2: the last busy cycle index before the timeout fires
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  function automatic logic [2:0] sat_naddr(input logic [2:0] n);
    return (n > 3'd5) ? 3'd5 : n;
  endfunction

  state_t          state, state_next;
  state_t          after_cmd1, after_addr, after_cmd2;
  logic [15:0]     cyc_cnt;
  logic [2:0]      addr_idx;
  logic [7:0]      rd_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            to_flag, to_hit;
  logic            lat_end, rd_end;
  logic            rb_sync_p0, rb_sync_p1;

  logic [7:0]  r_cmd1, r_cmd2, r_nread;
  logic [39:0] r_addr;
  logic [2:0]  r_naddr;
  logic        r_has_cmd2, r_wait_rb;

  always_comb begin
    after_cmd2 = r_wait_rb ? WB : ((r_nread != 8'd0) ? READ : DONE);
    after_addr = r_has_cmd2 ? CMD2 : after_cmd2;
    after_cmd1 = (r_naddr != 3'd0) ? ADDR : after_addr;
    lat_end    = (cyc_cnt == LAT_LAST);
    rd_end     = (cyc_cnt == RD_LAST);
    state_next = state;
    to_hit     = 1'b0;
    case (state)
      IDLE:    if (req_valid) state_next = CMD1;
      CMD1:    if (lat_end) state_next = after_cmd1;
      ADDR:    if (lat_end && (addr_idx == r_naddr - 3'd1)) state_next = after_addr;
      CMD2:    if (lat_end) state_next = after_cmd2;
      WB:      if (cyc_cnt == WB_LAST) state_next = WAIT_RB;
      WAIT_RB: begin
        // ready wins over a timeout landing in the same cycle
        if (rb_sync_p1) begin
          state_next = (r_nread != 8'd0) ? READ : DONE;
        end else if (to_cnt == TO_LAST) begin
          state_next = DONE;
          to_hit     = 1'b1;
        end
      end
      READ:    if (rd_end && (rd_cnt == r_nread - 8'd1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      addr_idx   <= '0;
      rd_cnt     <= '0;
      to_cnt     <= '0;
      to_flag    <= 1'b0;
      rb_sync_p0 <= 1'b1;
      rb_sync_p1 <= 1'b1;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      state      <= state_next;
      rb_sync_p0 <= rb_n;
      rb_sync_p1 <= rb_sync_p0;
      rd_valid   <= (state == READ) && (cyc_cnt == RP_LAST);
      if ((state == READ) && (cyc_cnt == RP_LAST)) rd_data <= io_in;
      if (state != state_next) begin
        cyc_cnt  <= '0;
        addr_idx <= '0;
        rd_cnt   <= '0;
      end else if ((state == ADDR) && lat_end) begin
        cyc_cnt  <= '0;
        addr_idx <= addr_idx + 3'd1;
      end else if ((state == READ) && rd_end) begin
        cyc_cnt <= '0;
        rd_cnt  <= rd_cnt + 8'd1;
      end else if (state != IDLE) begin
        cyc_cnt <= cyc_cnt + 16'd1;
      end
      // held at zero outside WAIT_RB, so it starts from zero on every entry
      to_cnt <= (state == WAIT_RB) ? to_cnt + 1'b1 : '0;
      if (state == IDLE)  to_flag <= 1'b0;
      else if (to_hit)    to_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && req_valid) begin
      r_cmd1     <= req_cmd1;
      r_has_cmd2 <= req_has_cmd2;
      r_cmd2     <= req_cmd2;
      r_addr     <= req_addr;
      r_naddr    <= sat_naddr(req_naddr);
      r_wait_rb  <= req_wait_rb;
      r_nread    <= req_nread;
    end
  end

  assign req_ready = (state == IDLE);
  assign done      = (state == DONE);
  assign timeout   = done && to_flag;
  assign ce_n      = (state == IDLE) || (state == DONE);
  assign cle       = (state == CMD1) || (state == CMD2);
  assign ale       = (state == ADDR);
  assign io_oe     = cle || ale;
  assign we_n      = !(io_oe && (cyc_cnt < WP_N));
  assign re_n      = !((state == READ) && (cyc_cnt < RP_N));

  always_comb begin
    io_out = 8'h00;
    case (state)
      CMD1: io_out = r_cmd1;
      CMD2: io_out = r_cmd2;
      ADDR: begin
        case (addr_idx)
          3'd0:    io_out = r_addr[7:0];
          3'd1:    io_out = r_addr[15:8];
          3'd2:    io_out = r_addr[23:16];
          3'd3:    io_out = r_addr[31:24];
          default: io_out = r_addr[39:32];
        endcase
      end
      default: io_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_nand_cmd_sequencer.sv
// Bench for nand_cmd_sequencer: a pin monitor plus a NAND device stub feed queues that
// are compared with a per-request model of latched bytes, read data and done timing.
module tb_nand_cmd_sequencer;
  localparam int T_WP = 2, T_WH = 2, T_RP = 2, T_REH = 2, T_WB = 4, TO_W = 4;
  localparam int LAT = T_WP + T_WH;
  localparam int RD = T_RP + T_REH;
  localparam int TO_BUSY = (1 << TO_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [7:0]  req_cmd1, req_cmd2, req_nread;
  logic        req_has_cmd2, req_wait_rb;
  logic [39:0] req_addr;
  logic [2:0]  req_naddr;
  logic [7:0]  rd_data, io_out, io_in;
  logic        rd_valid, done, timeout, ce_n, cle, ale, we_n, re_n, io_oe, rb_n;

  nand_cmd_sequencer #(.T_WP(T_WP), .T_WH(T_WH), .T_RP(T_RP), .T_REH(T_REH),
                       .T_WB(T_WB), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd1(req_cmd1), .req_has_cmd2(req_has_cmd2), .req_cmd2(req_cmd2),
    .req_addr(req_addr), .req_naddr(req_naddr), .req_wait_rb(req_wait_rb),
    .req_nread(req_nread), .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .timeout(timeout), .ce_n(ce_n), .cle(cle), .ale(ale), .we_n(we_n), .re_n(re_n),
    .io_out(io_out), .io_oe(io_oe), .io_in(io_in), .rb_n(rb_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor / device-stub state
  int         cyc = 0, acc_cyc = 0;
  int         done_cnt = 0, done_rel = 0, wlow = 0, dev_fixed = -1;
  logic       done_to = 1'b0;
  logic [9:0] lat_q[$];
  logic [7:0] rd_q[$], dev_q[$];
  logic       prev_we_n = 1'b1, prev_re_n = 1'b1, prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [7:0] b;
    if (!we_n) wlow++;
    if (!prev_we_n && we_n) begin
      chk("we_low_width", wlow, T_WP);
      chk("latch_ce_n", ce_n, 1'b0);
      chk("latch_io_oe", io_oe, 1'b1);
      lat_q.push_back({cle, ale, io_out});
      wlow = 0;
    end
    if (prev_re_n && !re_n) begin
      b = (dev_fixed >= 0) ? 8'(dev_fixed) : 8'($urandom);
      io_in = b;
      dev_q.push_back(b);
    end
    if (rd_valid) rd_q.push_back(rd_data);
    if (done) begin
      chk("done_width", prev_done, 1'b0);
      done_cnt++;
      done_rel = cyc - acc_cyc + 1;
      done_to  = timeout;
    end
    if (timeout) chk("timeout_with_done", done, 1'b1);
    prev_we_n = we_n;
    prev_re_n = re_n;
    prev_done = done;
  end

  task automatic scramble();
    req_cmd1 = 8'($urandom); req_cmd2 = 8'($urandom); req_has_cmd2 = 1'($urandom);
    req_addr = {8'($urandom), 32'($urandom)}; req_naddr = 3'($urandom);
    req_wait_rb = 1'($urandom); req_nread = 8'($urandom);
  endtask

  // One request: model, drive, wait for done, compare. h = relative cycle at which
  // the device releases R/B# (low from cycle 1 until then).
  task automatic do_req(input logic [7:0] c1, input logic h2, input logic [7:0] c2,
                        input logic [39:0] a, input logic [2:0] na, input logic wr,
                        input logic [7:0] nr, input int h, input logic hold,
                        output int waits);
    logic [9:0] exp_lat[$];
    int na_c, s, e, c, exp_done, exp_nrd, d0, k;
    logic exp_to;
    na_c = (na > 3'd5) ? 5 : int'(na);
    exp_lat.push_back({2'b10, c1});
    for (int i = 0; i < na_c; i++) exp_lat.push_back({2'b01, a[8*i +: 8]});
    if (h2) exp_lat.push_back({2'b10, c2});
    s = 1 + exp_lat.size() * LAT;
    exp_to = 1'b0;
    exp_nrd = int'(nr);
    if (!wr) begin
      exp_done = s + int'(nr) * RD;
    end else begin
      e = s + T_WB;
      c = (h + 2 > e) ? h + 2 : e;
      if (c - e < TO_BUSY) begin
        exp_done = c + 1 + int'(nr) * RD;
      end else begin
        exp_to = 1'b1; exp_nrd = 0; exp_done = e + TO_BUSY;
      end
    end

    req_cmd1 = c1; req_has_cmd2 = h2; req_cmd2 = c2; req_addr = a;
    req_naddr = na; req_wait_rb = wr; req_nread = nr; req_valid = 1'b1;
    waits = 0;
    do begin @(negedge clk); waits++; end while (!req_ready && waits < 200);
    lat_q.delete(); rd_q.delete(); dev_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!hold) begin
      req_valid = 1'b0;
      scramble();
    end
    k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(negedge clk); #1;
      if (wr) rb_n = ((cyc - acc_cyc + 1) >= h);
      k++;
    end
    rb_n = 1'b1;
    chk("done_seen", done_cnt - d0, 1);
    chk("done_cycle", done_rel, exp_done);
    chk("timeout_flag", done_to, exp_to);
    chk("latch_count", lat_q.size(), exp_lat.size());
    for (int i = 0; i < lat_q.size() && i < exp_lat.size(); i++)
      chk("latch_byte", lat_q[i], exp_lat[i]);
    chk("read_count", rd_q.size(), exp_nrd);
    chk("device_reads", dev_q.size(), exp_nrd);
    for (int i = 0; i < rd_q.size() && i < dev_q.size(); i++)
      chk("read_data", rd_q[i], dev_q[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, w2, k, d0;
    logic [7:0] first_rd;
    rst_n = 1'b0; req_valid = 1'b1; rb_n = 1'b1; io_in = 8'h00;
    scramble();
    req_naddr = 3'd0;

    // reset held with a pending request
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_ce_n", ce_n, 1'b1);
    chk("rst_we_n", we_n, 1'b1);
    chk("rst_re_n", re_n, 1'b1);
    chk("rst_cle_ale", {cle, ale}, 2'b00);
    chk("rst_io", {io_oe, io_out}, 9'h000);
    chk("rst_rd", {rd_valid, rd_data}, 9'h000);
    chk("rst_done_to", {done, timeout}, 2'b00);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_accept", ce_n, 1'b1);

    // READ STATUS
    dev_fixed = 32'he0;
    do_req(8'h70, 1'b0, 8'h00, 40'h0, 3'd0, 1'b0, 8'd1, 0, 1'b0, w);
    first_rd = (rd_q.size() > 0) ? rd_q[0] : 8'h00;
    chk("status_byte", first_rd, 8'he0);
    dev_fixed = -1;

    // PAGE READ with R/B# busy inside WAIT_RB
    do_req(8'h00, 1'b1, 8'h30, 40'h0403020100, 3'd5, 1'b1, 8'd4, 42, 1'b0, w);

    // R/B# never releases: timeout, reads skipped
    do_req(8'h60, 1'b1, 8'hd0, 40'h030201, 3'd3, 1'b1, 8'd5, 100000, 1'b0, w);

    // clamp naddr=7 to 5, then back-to-back with req_valid held
    do_req(8'h90, 1'b0, 8'h00, 40'hA5A4A3A2A1, 3'd7, 1'b0, 8'd2, 0, 1'b1, w);
    do_req(8'h90, 1'b0, 8'h00, 40'hA5A4A3A2A1, 3'd7, 1'b0, 8'd2, 0, 1'b0, w2);
    chk("b2b_accept_wait", w2, 1);

    // reset during ADDR byte 2
    req_cmd1 = 8'h00; req_has_cmd2 = 1'b1; req_cmd2 = 8'h30; req_addr = 40'h0403020100;
    req_naddr = 3'd5; req_wait_rb = 1'b0; req_nread = 8'd1; req_valid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!req_ready && k < 200);
    lat_q.delete();
    @(posedge clk); #1;
    req_valid = 1'b0;
    d0 = done_cnt;
    k = 0;
    while (!(lat_q.size() == 4 && ale && we_n) && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    chk("midop_reached", k < 200, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midop_ce_n", ce_n, 1'b1);
    chk("midop_ale", ale, 1'b0);
    chk("midop_io_oe", io_oe, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midop_no_done", done_cnt - d0, 0);
    do_req(8'h00, 1'b1, 8'h30, 40'h0403020100, 3'd5, 1'b0, 8'd2, 0, 1'b0, w);

    // randomized requests
    repeat (40) begin
      do_req(8'($urandom), 1'($urandom), 8'($urandom), {8'($urandom), 32'($urandom)},
             3'($urandom), 1'($urandom), 8'($urandom_range(0, 6)),
             int'($urandom_range(1, 45)), 1'b0, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
